// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: time-shares one combinational ALU among N_REQ
// requesters using round-robin arbitration and a req/done handshake.
//
// Ports:
//   clk          - system clock, rising edge
//   rstN         - synchronous active-low reset
//   req          - per-requester request level, held until own done
//   a_in, b_in   - packed operands, requester i at [i*WIDTH +: WIDTH]
//   op_in        - packed op codes, requester i at [i*3 +: 3]
//   alu_a/alu_b  - registered operands driving the shared ALU
//   alu_selectOp - registered op driving the shared ALU (idle=6 when unused)
//   alu_dataOut  - combinational ALU result
//   result       - captured ALU result, held until next capture
//   done         - one-hot single-cycle completion pulse
//   busy         - transaction in flight (EXEC or RESP)
module alu_share_arbiter #(
   parameter int WIDTH = 12,
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic                   clk,
   input  logic                   rstN,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] a_in,
   input  logic [N_REQ*WIDTH-1:0] b_in,
   input  logic [N_REQ*3-1:0]     op_in,
   output logic [WIDTH-1:0]       alu_a,
   output logic [WIDTH-1:0]       alu_b,
   output logic [2:0]             alu_selectOp,
   input  logic [WIDTH-1:0]       alu_dataOut,
   output logic [WIDTH-1:0]       result,
   output logic [N_REQ-1:0]       done,
   output logic                   busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [2:0] OP_IDLE = 3'd6;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] rr_q, rr_d;
   logic [IDX_W-1:0] sel_q, sel_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [N_REQ-1:0] done_q, done_d;

   logic             win_vld;
   logic [IDX_W-1:0] win_idx;
   logic [WIDTH-1:0] win_a;
   logic [WIDTH-1:0] win_b;
   logic [2:0]       win_op;
   int               cand;

   // Round-robin search: start at rr_q, ascend, wrap; first high bit wins.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      win_a   = '0;
      win_b   = '0;
      win_op  = '0;
      cand    = 0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = (int'(rr_q) + k) % N_REQ;
         if (!win_vld && req[cand]) begin
            win_vld = 1'b1;
            win_idx = cand[IDX_W-1:0];
            win_a   = a_in[cand*WIDTH +: WIDTH];
            win_b   = b_in[cand*WIDTH +: WIDTH];
            win_op  = op_in[cand*3 +: 3];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      sel_d   = sel_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      res_d   = res_q;
      done_d  = done_q;
      unique case (state_q)
         ST_IDLE: begin
            op_d = OP_IDLE;
            if (win_vld) begin
               sel_d   = win_idx;
               a_d     = win_a;
               b_d     = win_b;
               op_d    = win_op;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            res_d         = alu_dataOut;
            done_d        = '0;
            done_d[sel_q] = 1'b1;
            rr_d    = (sel_q == LAST_IDX) ? '0 : sel_q + 1'b1;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            done_d  = '0;
            op_d    = OP_IDLE;
            state_d = ST_IDLE;
         end
         default: begin
            done_d  = '0;
            op_d    = OP_IDLE;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         state_q <= ST_IDLE;
         rr_q    <= '0;
         sel_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= OP_IDLE;
         res_q   <= '0;
         done_q  <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         sel_q   <= sel_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
         done_q  <= done_d;
      end
   end

   assign alu_a        = a_q;
   assign alu_b        = b_q;
   assign alu_selectOp = op_q;
   assign result       = res_q;
   assign done         = done_q;
   assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed scoreboard bench for alu_share_arbiter,
// with a behavioural shared ALU attached to the alu_* ports.
module tb_alu_share_arbiter;

   localparam int W = 12;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rstN;
   logic [N-1:0]   req;
   logic [N*W-1:0] a_in;
   logic [N*W-1:0] b_in;
   logic [N*3-1:0] op_in;
   logic [W-1:0]   alu_a;
   logic [W-1:0]   alu_b;
   logic [2:0]     alu_selectOp;
   logic [W-1:0]   alu_dataOut;
   logic [W-1:0]   result;
   logic [N-1:0]   done;
   logic           busy;

   typedef struct packed {
      logic [N-1:0] d;
      logic [W-1:0] r;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   nt;

   alu_share_arbiter #(.WIDTH(W), .N_REQ(N), .IDX_W(2)) dut (
      .clk(clk), .rstN(rstN), .req(req),
      .a_in(a_in), .b_in(b_in), .op_in(op_in),
      .alu_a(alu_a), .alu_b(alu_b), .alu_selectOp(alu_selectOp),
      .alu_dataOut(alu_dataOut), .result(result),
      .done(done), .busy(busy)
   );

   always #5 clk = ~clk;

   // Shared ALU: clr, pass, add, sub, mul, inc; anything else gives 0.
   always_comb begin
      alu_dataOut = '0;
      case (alu_selectOp)
         3'd1: alu_dataOut = alu_a;
         3'd2: alu_dataOut = alu_a + alu_b;
         3'd3: alu_dataOut = alu_a - alu_b;
         3'd4: alu_dataOut = alu_a * alu_b;
         3'd5: alu_dataOut = alu_a + 12'd1;
         default: alu_dataOut = '0;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic setop(input int i, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2:0] op);
      a_in[i*W +: W] = a;
      b_in[i*W +: W] = b;
      op_in[i*3 +: 3] = op;
   endtask

   task automatic push(input logic [N-1:0] d, input logic [W-1:0] r);
      exp_t e;
      e.d = d;
      e.r = r;
      sb.push_back(e);
   endtask

   // Wait up to max negedges for a done pulse, then pop and compare.
   task automatic wait_done(input int max, output int ticks);
      exp_t e;
      ticks = 0;
      do begin
         @(negedge clk);
         ticks++;
      end while (done === '0 && ticks < max);
      if (done === '0) begin
         chk("done_timeout", 32'(done), 32'hF);
      end else if (sb.size() == 0) begin
         chk("unexpected_done", 32'(done), 32'h0);
      end else begin
         e = sb.pop_front();
         chk("done_onehot", 32'($onehot0(done)), 32'd1);
         chk("done_who", 32'(done), 32'(e.d));
         chk("result", 32'(result), 32'(e.r));
      end
   endtask

   initial begin
      rstN  = 1'b0;
      req   = '0;
      a_in  = '0;
      b_in  = '0;
      op_in = '0;

      // Reset and idle
      repeat (2) @(negedge clk);
      chk("rst_alu_a", 32'(alu_a), 32'd0);
      chk("rst_alu_b", 32'(alu_b), 32'd0);
      chk("rst_op", 32'(alu_selectOp), 32'd6);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rstN = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_op", 32'(alu_selectOp), 32'd6);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);

      // Single request: 10 + 3
      setop(0, 12'd10, 12'd3, 3'd2);
      req = 4'b0001;
      push(4'b0001, 12'd13);
      @(negedge clk);
      chk("grant_alu_a", 32'(alu_a), 32'd10);
      chk("grant_alu_b", 32'(alu_b), 32'd3);
      chk("grant_op", 32'(alu_selectOp), 32'd2);
      chk("exec_busy", 32'(busy), 32'd1);
      chk("exec_done", 32'(done), 32'd0);
      wait_done(4, nt);
      chk("latency", 32'(nt), 32'd1);
      chk("resp_busy", 32'(busy), 32'd1);
      req = '0;
      @(negedge clk);
      chk("post_done", 32'(done), 32'd0);
      chk("post_busy", 32'(busy), 32'd0);
      chk("post_op", 32'(alu_selectOp), 32'd6);
      chk("post_result_hold", 32'(result), 32'd13);

      // Signed multiply and wrap
      setop(1, 12'd20, 12'hFE2, 3'd4);
      req = 4'b0010;
      push(4'b0010, 12'hDA8);
      wait_done(5, nt);
      chk("mul_latency", 32'(nt), 32'd2);
      req = '0;
      @(negedge clk);
      chk("mul_done_clear", 32'(done), 32'd0);
      setop(1, 12'd100, 12'd100, 3'd4);
      req = 4'b0010;
      push(4'b0010, 12'd1808);
      wait_done(5, nt);
      req = '0;
      @(negedge clk);

      // Late operand change during EXEC has no effect
      setop(0, 12'd7, 12'd2, 3'd3);
      req = 4'b0001;
      push(4'b0001, 12'd5);
      @(negedge clk);
      a_in[0 +: W] = 12'd100;
      wait_done(4, nt);
      req = '0;
      @(negedge clk);

      // Reset pulse in IDLE to bring the pointer back to 0
      rstN = 1'b0;
      @(negedge clk);
      rstN = 1'b1;

      // Contention: all four hold req, sub each
      setop(0, 12'd50, 12'd8, 3'd3);
      setop(1, 12'd9, 12'd20, 3'd3);
      setop(2, 12'd0, 12'd1, 3'd3);
      setop(3, 12'd2047, 12'hFFF, 3'd3);
      req = 4'b1111;
      push(4'b0001, 12'd42);
      push(4'b0010, 12'hFF5);
      push(4'b0100, 12'hFFF);
      push(4'b1000, 12'h800);
      push(4'b0001, 12'd42);
      for (int i = 0; i < 5; i++) begin
         wait_done(6, nt);
         chk("rr_spacing", 32'(nt), (i == 0) ? 32'd2 : 32'd3);
      end
      req = '0;
      @(negedge clk);
      chk("rr_end_done", 32'(done), 32'd0);
      chk("rr_end_busy", 32'(busy), 32'd0);

      // Mid-transaction reset drops the transaction
      setop(2, 12'h123, 12'd0, 3'd1);
      req = 4'b0100;
      @(negedge clk);
      chk("mid_busy", 32'(busy), 32'd1);
      rstN = 1'b0;
      @(negedge clk);
      chk("mid_done", 32'(done), 32'd0);
      chk("mid_result", 32'(result), 32'd0);
      chk("mid_busy_clr", 32'(busy), 32'd0);
      chk("mid_op", 32'(alu_selectOp), 32'd6);
      rstN = 1'b1;
      req = '0;
      @(negedge clk);
      chk("mid_no_done", 32'(done), 32'd0);

      // Pointer cleared by reset: requester 0 beats 1
      setop(0, 12'd5, 12'd6, 3'd2);
      setop(1, 12'd9, 12'd1, 3'd3);
      req = 4'b0011;
      push(4'b0001, 12'd11);
      wait_done(4, nt);
      req = '0;
      @(negedge clk);

      // Requester 2 alone served normally
      req = 4'b0100;
      push(4'b0100, 12'h123);
      wait_done(4, nt);
      req = '0;
      @(negedge clk);
      chk("final_done", 32'(done), 32'd0);
      chk("final_result_hold", 32'(result), 32'h123);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
